dmem_responder: RTL and testbench

Memory-side responder for the core's load/store port: accepts one request at a time over a valid/ready channel and performs little-endian byte/half/word accesses on an internal word-organised RAM. Returns the load data, sign- or zero-extended, over a registered response channel. Sits between the core's load/store path and on-chip data storage, and replaces the zero-latency data memory so the core can be tested against wait states and error responses.

---
 rtl/dmem_responder.sv | 188 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder over a word-organised RAM with
// configurable wait states, little-endian lanes, and an error response path.
module dmem_responder #(
  parameter int    DATA_WIDTH = 32,
  parameter int    ADDR_WIDTH = 32,
  parameter int    DEPTH      = 256,
  parameter int    LATENCY    = 1,
  parameter string MEM_INIT   = ""
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]            req_size,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [1:0]            dbg_state_o
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready,
  // a response transfers where rsp_valid && rsp_ready; the offering side holds
  // its payload stable until the transfer.

  localparam int IDXW = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rerr_q, rerr_d;

  logic [IDXW+1:0]       addr_q;
  logic [2:0]            size_q;
  logic                  write_q;
  logic                  err_q;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  function automatic logic req_illegal(input logic wr, input logic [2:0] sz,
                                       input logic [ADDR_WIDTH-1:0] a);
    logic bad;
    bad = 1'b0;
    case (sz)
      3'b000:  bad = 1'b0;
      3'b001:  bad = a[0];
      3'b010:  bad = |a[1:0];
      3'b100:  bad = wr;
      3'b101:  bad = wr | a[0];
      default: bad = 1'b1;
    endcase
    // DEPTH is a power of two, so any set bit above the index range is out of bounds.
    if (|a[ADDR_WIDTH-1:IDXW+2]) bad = 1'b1;
    return bad;
  endfunction

  logic acc, acc_err;
  assign acc     = req_valid && (state_q == ST_IDLE);
  assign acc_err = req_illegal(req_write, req_size, req_addr);

  // With zero wait states the response is built on the acceptance edge, so it
  // must come straight from the request inputs rather than the latched copy.
  logic [IDXW+1:0]       sel_addr;
  logic [2:0]            sel_size;
  logic                  sel_write, sel_err;
  logic [DATA_WIDTH-1:0] rd_word, lane, ext_data;

  assign sel_addr  = (state_q == ST_IDLE) ? req_addr[IDXW+1:0] : addr_q;
  assign sel_size  = (state_q == ST_IDLE) ? req_size  : size_q;
  assign sel_write = (state_q == ST_IDLE) ? req_write : write_q;
  assign sel_err   = (state_q == ST_IDLE) ? acc_err   : err_q;
  assign rd_word   = mem_q[sel_addr[IDXW+1:2]];
  assign lane      = rd_word >> {sel_addr[1:0], 3'b000};

  always_comb begin
    ext_data = lane;
    case (sel_size)
      3'b000:  ext_data = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ext_data = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ext_data = {24'd0, lane[7:0]};
      3'b101:  ext_data = {16'd0, lane[15:0]};
      default: ext_data = lane;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (LATENCY > 0) begin
            state_d = ST_WAIT;
            cnt_d   = LAT_M1;
          end else begin
            state_d = ST_RESP;
            rdata_d = (sel_write || sel_err) ? '0 : ext_data;
            rerr_d  = sel_err;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          rdata_d = (sel_write || sel_err) ? '0 : ext_data;
          rerr_d  = sel_err;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      addr_q  <= req_addr[IDXW+1:0];
      size_q  <= req_size;
      write_q <= req_write;
      err_q   <= acc_err;
    end
  end

  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] wlane;

  always_comb begin
    be    = 4'b0000;
    wlane = req_wdata;
    case (req_size)
      3'b000: begin
        be    = 4'b0001 << req_addr[1:0];
        wlane = {4{req_wdata[7:0]}};
      end
      3'b001: begin
        be    = req_addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{req_wdata[15:0]}};
      end
      3'b010:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Stores commit on the acceptance edge; RAM has no reset.
  always_ff @(posedge clk) begin
    if (acc && req_write && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[req_addr[IDXW+1:2]][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = rerr_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 1, 0, 3) driven by
// directed vectors; a per-instance monitor checks responses from a queue.
module tb_dmem_responder;

  localparam int N = 3;
  localparam logic [2:0] SZ_B = 3'b000, SZ_H = 3'b001, SZ_W = 3'b010,
                         SZ_BU = 3'b100, SZ_HU = 3'b101, SZ_BAD = 3'b011;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        req_valid [N];
  logic        req_ready [N];
  logic        req_write [N];
  logic [31:0] req_addr  [N];
  logic [2:0]  req_size  [N];
  logic [31:0] req_wdata [N];
  logic        rsp_valid [N];
  logic        rsp_ready [N];
  logic [31:0] rsp_rdata [N];
  logic        rsp_err   [N];
  logic [1:0]  dbg_state [N];

  dmem_responder #(.LATENCY(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_size(req_size[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .dbg_state_o(dbg_state[0]));

  dmem_responder #(.LATENCY(0)) u_lat0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_size(req_size[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .dbg_state_o(dbg_state[1]));

  dmem_responder #(.LATENCY(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_write(req_write[2]), .req_addr(req_addr[2]), .req_size(req_size[2]),
    .req_wdata(req_wdata[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]), .dbg_state_o(dbg_state[2]));

  // Scoreboard: {err, rdata} expected per instance, plus the acceptance edge.
  logic [32:0] exp_q [N][$];
  int unsigned acc_q [N][$];
  int checks = 0;
  int passes = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endfunction

  function automatic int lat_of(input int d);
    case (d)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_mon
    bit          seen = 1'b0;
    int unsigned first_cyc = 0;
    always @(negedge clk) begin
      if (!rst_n) begin
        seen <= 1'b0;
      end else if (rsp_valid[g]) begin
        if (exp_q[g].size() == 0) begin
          check($sformatf("unexpected_rsp_d%0d", g), 32'(rsp_valid[g]), 32'd0);
        end else begin
          check($sformatf("rdata_d%0d", g), rsp_rdata[g], exp_q[g][0][31:0]);
          check($sformatf("err_d%0d", g), 32'(rsp_err[g]), 32'(exp_q[g][0][32]));
          check($sformatf("req_ready_busy_d%0d", g), 32'(req_ready[g]), 32'd0);
          if (rsp_ready[g]) begin
            check($sformatf("latency_d%0d", g),
                  32'((seen ? first_cyc : cyc) + 1 - acc_q[g][0]), 32'(lat_of(g) + 1));
            void'(exp_q[g].pop_front());
            void'(acc_q[g].pop_front());
            seen <= 1'b0;
          end else if (!seen) begin
            seen      <= 1'b1;
            first_cyc <= cyc;
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the acceptance edge.
  task automatic issue(input int d, input logic wr, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee, input bit expect_rsp,
                       output int unsigned acc);
    int n;
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_size[d]  = sz;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    acc = 0;
    n = 0;
    @(negedge clk);
    while (!req_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[d]) begin
      check($sformatf("accept_timeout_d%0d", d), 32'(req_ready[d]), 32'd1);
    end else begin
      acc = cyc + 1;
      if (expect_rsp) begin
        exp_q[d].push_back({ee, er});
        acc_q[d].push_back(acc);
      end
    end
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while (exp_q[d].size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q[d].size() != 0) check($sformatf("drain_timeout_d%0d", d), 32'(exp_q[d].size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int d, input logic wr, input logic [2:0] sz,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] er, input logic ee);
    int unsigned acc;
    issue(d, wr, sz, a, wd, er, ee, 1'b1, acc);
    drain(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int unsigned a0, a1, a2;
    rst_n = 1'b0;
    for (int d = 0; d < N; d++) begin
      req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = '0;
      req_size[d]  = SZ_W; req_wdata[d] = '0;  rsp_ready[d] = 1'b1;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < N; d++) begin
      check($sformatf("reset_req_ready_d%0d", d), 32'(req_ready[d]), 32'd1);
      check($sformatf("reset_rsp_valid_d%0d", d), 32'(rsp_valid[d]), 32'd0);
      check($sformatf("reset_rsp_rdata_d%0d", d), rsp_rdata[d], 32'd0);
      check($sformatf("reset_rsp_err_d%0d", d), 32'(rsp_err[d]), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Word round trip and lane tests on the LATENCY=1 instance.
    run(0, 1, SZ_W, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    run(0, 0, SZ_W, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    run(0, 1, SZ_W, 32'h20, 32'h00000000, 32'h0, 0);
    run(0, 1, SZ_W, 32'h24, 32'h00000000, 32'h0, 0);
    run(0, 1, SZ_B, 32'h23, 32'hAAAAAA80, 32'h0, 0);
    run(0, 1, SZ_H, 32'h20, 32'h5555F00F, 32'h0, 0);
    run(0, 0, SZ_W,  32'h20, 32'h0, 32'h8000F00F, 0);
    run(0, 0, SZ_B,  32'h23, 32'h0, 32'hFFFFFF80, 0);
    run(0, 0, SZ_BU, 32'h23, 32'h0, 32'h00000080, 0);
    run(0, 0, SZ_H,  32'h20, 32'h0, 32'hFFFFF00F, 0);
    run(0, 0, SZ_HU, 32'h20, 32'h0, 32'h0000F00F, 0);
    run(0, 0, SZ_B,  32'h20, 32'h0, 32'h0000000F, 0);
    run(0, 0, SZ_H,  32'h22, 32'h0, 32'hFFFF8000, 0);
    run(0, 0, SZ_HU, 32'h22, 32'h0, 32'h00008000, 0);
    run(0, 1, SZ_W, 32'h3FC, 32'hA5A5A5A5, 32'h0, 0);
    run(0, 0, SZ_W, 32'h3FC, 32'h0, 32'hA5A5A5A5, 0);

    // Illegal requests: error response, no side effects.
    run(0, 0, SZ_W,   32'h22,  32'h0,        32'h0, 1);
    run(0, 1, SZ_H,   32'h21,  32'hFFFFFFFF, 32'h0, 1);
    run(0, 1, SZ_BU,  32'h24,  32'hFFFFFFFF, 32'h0, 1);
    run(0, 1, SZ_HU,  32'h24,  32'hFFFFFFFF, 32'h0, 1);
    run(0, 0, SZ_W,   32'h400, 32'h0,        32'h0, 1);
    run(0, 1, SZ_W,   32'h420, 32'hFFFFFFFF, 32'h0, 1);
    run(0, 0, SZ_BAD, 32'h20,  32'h0,        32'h0, 1);
    run(0, 1, SZ_BAD, 32'h24,  32'hFFFFFFFF, 32'h0, 1);
    run(0, 0, SZ_W, 32'h20, 32'h0, 32'h8000F00F, 0);
    run(0, 0, SZ_W, 32'h24, 32'h0, 32'h00000000, 0);

    // Backpressure with a stray store presented while busy.
    rsp_ready[0] = 1'b0;
    issue(0, 0, SZ_B, 32'h23, 32'h0, 32'hFFFFFF80, 0, 1'b1, a0);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_size[0] = SZ_W;
    req_addr[0]  = 32'h24; req_wdata[0] = 32'hBAD0BAD0;
    repeat (7) begin @(posedge clk); #1; end
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    rsp_ready[0] = 1'b1;
    drain(0);
    run(0, 0, SZ_W, 32'h24, 32'h0, 32'h00000000, 0);

    // LATENCY=0 back-to-back throughput.
    issue(1, 1, SZ_W, 32'h40, 32'h11223344, 32'h0, 0, 1'b1, a0);
    issue(1, 0, SZ_W, 32'h40, 32'h0, 32'h11223344, 0, 1'b1, a1);
    issue(1, 0, SZ_H, 32'h42, 32'h0, 32'h00001122, 0, 1'b1, a2);
    check("period_lat0_a", a1 - a0, 32'd2);
    check("period_lat0_b", a2 - a1, 32'd2);
    issue(1, 0, SZ_B, 32'h41, 32'h0, 32'h00000033, 0, 1'b1, a0);
    check("period_lat0_c", a0 - a2, 32'd2);
    drain(1);

    // LATENCY=3 back-to-back throughput.
    issue(2, 1, SZ_W,  32'h44, 32'hCAFEF00D, 32'h0, 0, 1'b1, a0);
    issue(2, 0, SZ_BU, 32'h47, 32'h0, 32'h000000CA, 0, 1'b1, a1);
    issue(2, 0, SZ_B,  32'h44, 32'h0, 32'h0000000D, 0, 1'b1, a2);
    check("period_lat3_a", a1 - a0, 32'd5);
    check("period_lat3_b", a2 - a1, 32'd5);
    drain(2);

    // Reset while waiting: response dropped, store stays committed.
    issue(2, 1, SZ_W, 32'h30, 32'h12345678, 32'h0, 0, 1'b0, a0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midreset_req_ready", 32'(req_ready[2]), 32'd1);
    check("midreset_rsp_valid", 32'(rsp_valid[2]), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(2, 0, SZ_W, 32'h30, 32'h0, 32'h12345678, 0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
